// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcodes, operation classes, decode FSM states and ID/EX bundle.
package riscv_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;

  // OP_NONE is encoded as 0 so an all-zero ID/EX entry reads as the reset value.
  typedef enum logic [3:0] {
    OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG
  } op_e;

  typedef enum logic {DECODE, STALL} dec_state_e;

  typedef struct packed {
    logic        valid;
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic        illegal;
  } id_ex_t;

  function automatic op_e op_of(input logic [6:0] opc);
    return opc == OPC_LUI    ? OP_LUI    :
           opc == OPC_AUIPC  ? OP_AUIPC  :
           opc == OPC_JAL    ? OP_JAL    :
           opc == OPC_JALR   ? OP_JALR   :
           opc == OPC_BRANCH ? OP_BRANCH :
           opc == OPC_LOAD   ? OP_LOAD   :
           opc == OPC_STORE  ? OP_STORE  :
           opc == OPC_IMM    ? OP_IMM    :
           opc == OPC_REG    ? OP_REG    : OP_NONE;
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended RV32I immediate for the instruction's format.
//   instr : raw instruction word
//   op    : operation class selecting I/S/B/U/J format
//   imm   : immediate, 0 for R-type and unknown opcodes
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  op_e         op,
  output logic [31:0] imm
);
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        unused_opc;
  assign unused_opc = ^instr[6:0];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm = op inside {OP_JALR, OP_LOAD, OP_IMM} ? imm_i :
               op == OP_STORE                       ? imm_s :
               op == OP_BRANCH                      ? imm_b :
               op inside {OP_LUI, OP_AUIPC}         ? imm_u :
               op == OP_JAL                         ? imm_j : 32'h0;
endmodule

// File: rtl/decode.sv
// decode: RV32I ID stage with load-use stall and ID/EX pipeline register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   instr_i           : instruction word from fetch (0 = bubble)
//   flush_i           : kill the instruction currently in decode
//   stall_o           : combinational stall request to fetch
//   valid_o .. imm_o  : ID/EX register fields for execute
//   illegal_o         : unrecognised opcode in ID/EX
module decode
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        valid_o,
  output op_e         op_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic [31:0] imm_o,
  output logic        illegal_o
);
  dec_state_e  state_q, state_d;
  logic [31:0] hold_q, cur, imm;
  id_ex_t      idex_q, idex_d, dec;
  op_e         op;
  logic        bubble, use_rs1, use_rs2, hazard;

  // In STALL the held instruction replaces whatever fetch is presenting.
  assign cur = state_q == STALL ? hold_q : instr_i;
  assign op  = op_of(cur[6:0]);

  imm_gen u_imm (.instr(cur), .op(op), .imm(imm));

  always_comb begin
    bubble  = cur == 32'h0;
    use_rs1 = !bubble && !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    use_rs2 = op inside {OP_REG, OP_STORE, OP_BRANCH};
    dec = '{valid: !bubble, op: op, rd: cur[11:7], rs1: cur[19:15], rs2: cur[24:20],
            funct3: cur[14:12], funct7b5: cur[30], imm: imm,
            illegal: !bubble && op == OP_NONE};
    // A bubble already sits in ID/EX while in STALL, so the state guard is belt and braces.
    hazard = !flush_i && state_q == DECODE && idex_q.valid && idex_q.op == OP_LOAD &&
             idex_q.rd != 5'd0 &&
             ((use_rs1 && cur[19:15] == idex_q.rd) || (use_rs2 && cur[24:20] == idex_q.rd));
    state_d = hazard ? STALL : DECODE;
    idex_d  = (flush_i || hazard) ? '0 : dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DECODE;
      hold_q  <= 32'h0;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= flush_i ? 32'h0 : hazard ? instr_i : hold_q;
      idex_q  <= idex_d;
    end
  end

  assign stall_o    = hazard;
  assign valid_o    = idex_q.valid;
  assign op_o       = idex_q.op;
  assign rd_o       = idex_q.rd;
  assign rs1_o      = idex_q.rs1;
  assign rs2_o      = idex_q.rs2;
  assign funct3_o   = idex_q.funct3;
  assign funct7b5_o = idex_q.funct7b5;
  assign imm_o      = idex_q.imm;
  assign illegal_o  = idex_q.illegal;
endmodule

// File: tb/tb_decode.sv
// tb_decode: scoreboard bench for decode covering decode, hazards, flush and reset.
module tb_decode;
  import riscv_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0, stall_o;
  logic [31:0] instr_i = 32'h0;
  logic        valid_o, funct7b5_o, illegal_o;
  op_e         op_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o;
  logic [31:0] imm_o;
  id_ex_t      q[$];
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .flush_i(flush_i), .stall_o(stall_o),
    .valid_o(valid_o), .op_o(op_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct3_o(funct3_o), .funct7b5_o(funct7b5_o), .imm_o(imm_o), .illegal_o(illegal_o)
  );

  function automatic id_ex_t mk(input logic v, input op_e op, input logic [4:0] rd, rs1, rs2,
                                input logic [2:0] f3, input logic f7, input logic [31:0] imm,
                                input logic ill);
    return '{valid: v, op: op, rd: rd, rs1: rs1, rs2: rs2, funct3: f3, funct7b5: f7,
             imm: imm, illegal: ill};
  endfunction

  function automatic id_ex_t now_out();
    return '{valid: valid_o, op: op_o, rd: rd_o, rs1: rs1_o, rs2: rs2_o, funct3: funct3_o,
             funct7b5: funct7b5_o, imm: imm_o, illegal: illegal_o};
  endfunction

  id_ex_t bub, lw5, add6, addi1, sw5, lw0, add0, lw8, lui3;

  initial begin
    bub   = mk(0, OP_NONE,   0, 0, 0, 0, 0, 32'h0, 0);
    lw5   = mk(1, OP_LOAD,   5, 1, 0, 2, 0, 32'h0, 0);
    add6  = mk(1, OP_REG,    6, 5, 2, 0, 0, 32'h0, 0);
    addi1 = mk(1, OP_IMM,    1, 2, 5, 0, 0, 32'h5, 0);
    sw5   = mk(1, OP_STORE,  0, 1, 5, 2, 0, 32'h0, 0);
    lw0   = mk(1, OP_LOAD,   0, 1, 0, 2, 0, 32'h0, 0);
    add0  = mk(1, OP_REG,    6, 0, 0, 0, 0, 32'h0, 0);
    lw8   = mk(1, OP_LOAD,   8, 1, 0, 2, 0, 32'h0, 0);
    lui3  = mk(1, OP_LUI,    3, 8, 3, 5, 0, 32'h12345000, 0);
  end

  task automatic test_reset();
    #3;
    total++;
    if (now_out() !== '0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%h stall=%b want=%h stall=0", now_out(), stall_o, id_ex_t'('0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    instr_i = 32'h0;
    q.push_back(bub);
    @(posedge clk); #1;
    total++;
    begin
      id_ex_t e = q.pop_front(), g = now_out();
      if (g.valid !== e.valid || g.illegal !== e.illegal || stall_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_bubble got v=%b ill=%b stall=%b want v=0 ill=0 stall=0", g.valid, g.illegal, stall_o);
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] ins[7];
    id_ex_t      ex[7];
    ins = '{32'h00510093, 32'hFE000EE3, 32'h123451B7, 32'hFE50AE23, 32'hFF9FF06F, 32'h004100E7, 32'h0000007F};
    ex  = '{addi1,
            mk(1, OP_BRANCH, 29, 0, 0, 0, 1, 32'hFFFFFFFC, 0),
            lui3,
            mk(1, OP_STORE, 28, 1, 5, 2, 1, 32'hFFFFFFFC, 0),
            mk(1, OP_JAL, 0, 31, 25, 7, 1, 32'hFFFFFFF8, 0),
            mk(1, OP_JALR, 1, 2, 4, 0, 0, 32'h4, 0),
            mk(1, OP_NONE, 0, 0, 0, 0, 0, 32'h0, 1)};
    for (int i = 0; i < 7; i++) begin
      instr_i = ins[i];
      flush_i = 1'b0;
      q.push_back(ex[i]);
      @(posedge clk); #1;
      total++;
      begin
        id_ex_t e = q.pop_front(), g = now_out();
        if (g !== e) begin
          bad++;
          $display("FAIL decode[%0d] instr=%h got=%h want=%h", i, ins[i], g, e);
        end
      end
    end
  endtask

  task automatic test_hazard();
    logic [31:0] ins[11];
    logic        st[11];
    id_ex_t      ex[11];
    ins = '{32'h0000A283, 32'h00228333, 32'hFFFFFFFF, 32'h0, 32'h0000A283, 32'h0050A023,
            32'h00510093, 32'h0000A003, 32'h00000333, 32'h0000A403, 32'h123451B7};
    st  = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    ex  = '{lw5, bub, add6, bub, lw5, bub, sw5, lw0, add0, lw8, lui3};
    for (int i = 0; i < 11; i++) begin
      instr_i = ins[i];
      flush_i = 1'b0;
      q.push_back(ex[i]);
      #1;
      total++;
      if (stall_o !== st[i]) begin
        bad++;
        $display("FAIL hazard_stall[%0d] got=%b want=%b", i, stall_o, st[i]);
      end
      @(posedge clk); #1;
      total++;
      begin
        id_ex_t e = q.pop_front(), g = now_out();
        if (e.valid ? g !== e : {g.valid, g.illegal} !== 2'b00) begin
          bad++;
          $display("FAIL hazard_out[%0d] got=%h want=%h", i, g, e);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] ins[4];
    logic        fl[4];
    id_ex_t      ex[4];
    ins = '{32'h0000A283, 32'h00228333, 32'h0, 32'h00510093};
    fl  = '{0, 1, 0, 0};
    ex  = '{lw5, bub, bub, addi1};
    for (int i = 0; i < 4; i++) begin
      instr_i = ins[i];
      flush_i = fl[i];
      q.push_back(ex[i]);
      #1;
      total++;
      if (stall_o !== 1'b0) begin
        bad++;
        $display("FAIL flush_stall[%0d] got=%b want=0", i, stall_o);
      end
      @(posedge clk); #1;
      total++;
      begin
        id_ex_t e = q.pop_front(), g = now_out();
        if (e.valid ? g !== e : {g.valid, g.illegal} !== 2'b00) begin
          bad++;
          $display("FAIL flush_out[%0d] got=%h want=%h", i, g, e);
        end
      end
    end
    flush_i = 1'b0;
  endtask

  task automatic test_reset_in_stall();
    instr_i = 32'h0000A283;
    @(posedge clk); #1;
    instr_i = 32'h00228333;
    #1;
    total++;
    if (stall_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_stall_setup got=%b want=1", stall_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (now_out() !== '0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_stall got=%h stall=%b want=%h stall=0", now_out(), stall_o, id_ex_t'('0));
    end
    rst_n = 1'b1;
    instr_i = 32'h00510093;
    q.push_back(addi1);
    @(posedge clk); #1;
    total++;
    begin
      id_ex_t e = q.pop_front(), g = now_out();
      if (g !== e) begin
        bad++;
        $display("FAIL rst_after_stall got=%h want=%h", g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_hazard();
    test_flush();
    test_reset_in_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode.md
# decode

ID stage of the riskyprocessor pipeline, the consumer end of the fetch-to-decode interface. Takes the raw 32-bit RV32I word from fetch and decodes it into fields, operation class and sign-extended immediate. Drives the `stall_i` input of fetch and detects load-use hazards against the instruction it last issued. Registers the result into the ID/EX pipeline register for execute.

## Interface
- No parameters. XLEN is fixed at 32.
- `clk` in 1: clock
- `rst_n` in 1: asynchronous, active-low reset
- `instr_i` in 32: instruction word from fetch, registered there
- `flush_i` in 1: taken branch/jump from execute; kill the instruction currently in decode
- `stall_o` out 1: to fetch `stall_i`; combinational
- `valid_o` out 1: ID/EX entry holds a real instruction
- `op_o` out `op_e`: operation class
- `rd_o`, `rs1_o`, `rs2_o` out 5 each: register indices
- `funct3_o` out 3: funct3 field
- `funct7b5_o` out 1: `instr[30]`
- `imm_o` out 32: sign-extended immediate for the decoded format; 0 for R-type
- `illegal_o` out 1: unrecognised opcode

## Operation
**Operation class (`op_o`)**
- Classes: `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_LOAD`, `OP_STORE`, `OP_IMM`, `OP_REG`, `OP_NONE`.
- Immediate formats: I, S, B, U, J, per the RV32I spec. B and J immediates have bit 0 = 0.

**Word handling**
- `instr_i == 32'h0` is a bubble: fetch drives this value out of reset. Result is `valid_o=0`, `illegal_o=0`.
- Unknown opcode gives `valid_o=1`, `illegal_o=1`, `op_o=OP_NONE`.
- `rs2_o` is always `instr[24:20]`. Hazard checks use rs2 only for `OP_REG`, `OP_STORE` and `OP_BRANCH`.
- rs1 is ignored for hazard checks for `OP_LUI`, `OP_AUIPC` and `OP_JAL`.

**Load-use hazard**
- Condition: the ID/EX register holds `valid_o && op_o==OP_LOAD && rd_o!=0`, and the incoming instruction reads that `rd`.
- Action: assert `stall_o`, latch `instr_i` into `hold_q`, and load a bubble into ID/EX (`valid_o=0`; other fields don't-care, `illegal_o=0`).

**FSM**
- States: `DECODE`, `STALL`.
- `DECODE`:
  - Decodes `instr_i`.
  - On hazard, moves to `STALL`.
- `STALL`:
  - Decodes `hold_q`; `instr_i` is ignored.
  - `stall_o=0`. A second hazard is impossible because a bubble now sits in ID/EX.
  - Issues `hold_q` and returns to `DECODE`.
- Upstream contract: the instruction after the stalled one is presented on the first `DECODE` cycle after `STALL`.

**Flush**
- `flush_i` has priority over everything.
- Next edge: `valid_o=0`, `illegal_o=0`, state is `DECODE`, `hold_q` discarded.
- `stall_o` is forced to 0 in any cycle where `flush_i=1`.

## Timing
- Latency: `instr_i` is sampled at edge N and appears on the ID/EX outputs after edge N. This is one cycle.
- `stall_o` is combinational from `instr_i` and the ID/EX register, so fetch sees it in the same cycle.
- A load-use pair costs exactly one bubble cycle.
- Reset values (asynchronous):
  - state `DECODE`, `hold_q=0`
  - `valid_o=0`, `illegal_o=0`, `stall_o=0`
  - all field outputs 0, `op_o=OP_NONE`
- Reset during `STALL` abandons the held instruction.
- Rules for `x0`:
  - A load to `x0` never stalls.
  - `rd_o` is passed through unchanged; execute suppresses writes to `x0`.

## Structure
- Package `riscv_pkg` holds:
  - opcode localparams (`OPC_LOAD=7'b0000011`, etc.)
  - `op_e`
  - the FSM state enum `dec_state_e`
  - the `id_ex_t` struct bundling the ID/EX outputs
- One sub-module, `imm_gen`: purely combinational, inputs `instr[31:0]` and `op_e`, output `imm[31:0]`.
- The FSM, hazard compare, `hold_q` and the ID/EX register live in `decode`.

## Test plan
1. Reset then `instr_i=0` → `valid_o=0`, `illegal_o=0`, `stall_o=0`.
2. `32'h00510093` (addi x1,x2,5) → next cycle:
   - `op_o=OP_IMM`, `rd_o=1`, `rs1_o=2`, `imm_o=5`, `valid_o=1`.
3. Sign extension of immediates:
   - `32'hFE000EE3` (beq x0,x0,-4) → `op_o=OP_BRANCH`, `imm_o=32'hFFFFFFFC`.
   - `32'h123451B7` (lui x3) → `imm_o=32'h12345000`.
4. Load-use hazard: `32'h0000A283` (lw x5,0(x1)) then `32'h00228333` (add x6,x5,x2):
   - `stall_o=1` for one cycle, then one bubble (`valid_o=0`).
   - `instr_i` is changed to garbage during `STALL`; the add must still issue with `rs1_o=5`, `rs2_o=2`, `rd_o=6`.
5. Flush: the load-use pair from scenario 4 with `flush_i=1` in the stall cycle → `stall_o=0`, then `valid_o=0`, state `DECODE`, no add issued.
   - Separately: `rst_n` pulsed low while in `STALL` → all outputs go to their reset values immediately.
6. `32'h0000007F` → `valid_o=1`, `illegal_o=1`.
   - `lw x0` followed by a reader of `x0` → no stall.
